// File: rtl/redmule_job_ctrl.sv
// redmule_job_ctrl
//   Multi-job controller for the RedMulE accelerator. Jobs ({core, tag}) are
//   pushed from the register front-end into a small FIFO, popped one at a time
//   and sequenced through configuration, weight preload, compute and finish.
//   Each job ends with a one-cycle done or error event on its core's lane.
//   A per-state watchdog aborts a job that stalls in an active state.
//
// Ports
//   clk_i, rst_i, clear_i      clock, synchronous active-high reset, soft clear
//   job_valid_i/job_ready_o    job push handshake, with job_core_i / job_tag_i
//   cfg_start_o                one-cycle tiler start, coincident with the pop
//   cfg_valid_i, w_loaded_i,   progress inputs from tiler / loader / Z sink
//   z_done_i
//   abort_i                    software abort of the running job
//   timeout_cycles_i           watchdog threshold, 0 disables
//   idle_o .. finished_o       state decodes
//   evt_o[core][1:0]           per-core events, bit0 done, bit1 error
//   run_core_o, run_tag_o      identity of the running job
//   pending_o                  queued jobs, excluding the running one
//   timeout_o                  sticky: last job was killed by the watchdog
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no job running; pops the queue head when one is present
// S_CFG      | tiler configuring, waiting for cfg_valid_i
// S_STARTING | first weight tile loading, waiting for w_loaded_i
// S_COMPUTING| engine running, waiting for z_done_i
// S_FINISHED | one cycle: flush, done event
// S_ABORT    | one cycle: flush, error event
module redmule_job_ctrl #(
  parameter int unsigned NumJobs      = 2,
  parameter int unsigned NumCores     = 8,
  parameter int unsigned TagWidth     = 4,
  parameter int unsigned TimeoutWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [$clog2(NumCores)-1:0]        job_core_i,
  input  logic [TagWidth-1:0]                job_tag_i,
  output logic                               cfg_start_o,
  input  logic                               cfg_valid_i,
  input  logic                               w_loaded_i,
  input  logic                               z_done_i,
  input  logic                               abort_i,
  input  logic [TimeoutWidth-1:0]            timeout_cycles_i,
  output logic                               idle_o,
  output logic                               busy_o,
  output logic                               first_load_o,
  output logic                               flush_o,
  output logic                               finished_o,
  output logic [NumCores-1:0][1:0]           evt_o,
  output logic [$clog2(NumCores)-1:0]        run_core_o,
  output logic [TagWidth-1:0]                run_tag_o,
  output logic [$clog2(NumJobs+1)-1:0]       pending_o,
  output logic                               timeout_o
);

  localparam int unsigned CoreW = $clog2(NumCores);
  localparam int unsigned CntW  = $clog2(NumJobs + 1);
  localparam int unsigned PtrW  = (NumJobs > 1) ? $clog2(NumJobs) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_STARTING, S_COMPUTING, S_FINISHED, S_ABORT
  } state_e;

  state_e state, state_next;

  logic srst;
  assign srst = rst_i | clear_i;

  // ---------------- job FIFO ----------------
  logic [CoreW-1:0]    q_core [NumJobs];
  logic [TagWidth-1:0] q_tag  [NumJobs];
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [CntW-1:0]     count;
  logic                push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumJobs - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Ready depends only on the registered count, so a pop in the same cycle
  // never frees a slot for a push.
  assign job_ready_o = (count < CntW'(NumJobs));
  assign push        = job_valid_i & job_ready_o;
  assign pop         = (state == S_IDLE) && (count != '0);

  always_ff @(posedge clk_i) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CntW'(1);
      else if (pop && !push) count <= count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_core[wr_ptr] <= job_core_i;
      q_tag[wr_ptr]  <= job_tag_i;
    end
  end

  // ---------------- watchdog ----------------
  logic [TimeoutWidth-1:0] wd_cnt;
  logic                    active, wd_hit, wd_abort;

  assign active = (state == S_CFG) || (state == S_STARTING) || (state == S_COMPUTING);
  assign wd_hit = (timeout_cycles_i != '0) &&
                  (wd_cnt == timeout_cycles_i - TimeoutWidth'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (srst) state <= S_IDLE;
    else      state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // wd_abort marks an abort caused by the watchdog alone, which is what
  // sets the sticky timeout flag.
  always_comb begin
    state_next = state;
    wd_abort   = 1'b0;
    case (state)
      S_IDLE:      if (count != '0) state_next = S_CFG;
      S_CFG: begin
        if (abort_i)          state_next = S_ABORT;
        else if (wd_hit)      begin state_next = S_ABORT; wd_abort = 1'b1; end
        else if (cfg_valid_i) state_next = S_STARTING;
      end
      S_STARTING: begin
        if (abort_i)         state_next = S_ABORT;
        else if (wd_hit)     begin state_next = S_ABORT; wd_abort = 1'b1; end
        else if (w_loaded_i) state_next = S_COMPUTING;
      end
      S_COMPUTING: begin
        // A completing job wins over abort and watchdog.
        if (z_done_i)     state_next = S_FINISHED;
        else if (abort_i) state_next = S_ABORT;
        else if (wd_hit)  begin state_next = S_ABORT; wd_abort = 1'b1; end
      end
      S_FINISHED:  state_next = S_IDLE;
      S_ABORT:     state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // ---------------- job registers ----------------
  logic [CoreW-1:0]    run_core;
  logic [TagWidth-1:0] run_tag;
  logic                timeout_q;

  always_ff @(posedge clk_i) begin
    if (srst) begin
      wd_cnt    <= '0;
      run_core  <= '0;
      run_tag   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_next != state)    wd_cnt <= '0;
      else if (active && wd_cnt != '1) wd_cnt <= wd_cnt + TimeoutWidth'(1);
      if (pop) begin
        run_core  <= q_core[rd_ptr];
        run_tag   <= q_tag[rd_ptr];
        timeout_q <= 1'b0;
      end else if (wd_abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    idle_o       = (state == S_IDLE);
    busy_o       = (state != S_IDLE);
    first_load_o = (state == S_STARTING);
    flush_o      = (state == S_FINISHED) || (state == S_ABORT);
    finished_o   = (state == S_FINISHED);
    evt_o        = '0;
    if (state == S_FINISHED) evt_o[run_core][0] = 1'b1;
    if (state == S_ABORT)    evt_o[run_core][1] = 1'b1;
  end

  assign cfg_start_o = pop;
  assign run_core_o  = run_core;
  assign run_tag_o   = run_tag;
  assign pending_o   = count;
  assign timeout_o   = timeout_q;

endmodule
